// File: rtl/pc_stack.sv
// Fetch-stage program counter with increment, jump, PC-relative branch and a
// hardware call/return stack; stall, overflow-inhibit and sticky fault all freeze state.
module pc_stack #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter int               INC       = 1,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stahp,
  input  logic                     of,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         in,
  input  logic                     clear_fault,
  output logic [WIDTH-1:0]         out,
  output logic [WIDTH-1:0]         ret_top,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
  localparam logic [DW-1:0]    FULL_D = DW'(DEPTH);
  localparam logic [DW-1:0]    ONE_D  = DW'(1);

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_INC    = 3'd1,
    OP_JUMP   = 3'd2,
    OP_BRANCH = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } op_e;

  op_e              opc;
  logic [WIDTH-1:0] stk [DEPTH];
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] ret_addr;
  logic [DW-1:0]    depth_nxt;
  logic             fault_nxt;
  logic             push;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;

  assign opc      = op_e'(op);
  assign ret_addr = out + INC_W;
  assign top_idx  = AW'(depth - ONE_D);
  assign wr_idx   = AW'(depth);

  assign stack_full  = (depth == FULL_D);
  assign stack_empty = (depth == '0);
  assign ret_top     = stack_empty ? '0 : stk[top_idx];

  always_comb begin
    pc_nxt    = out;
    depth_nxt = depth;
    fault_nxt = fault;
    push      = 1'b0;
    if (clear_fault) begin
      fault_nxt = 1'b0;
    end else if (!fault && !stahp && !of) begin
      case (opc)
        OP_INC:    pc_nxt = out + INC_W;
        OP_JUMP:   pc_nxt = in;
        OP_BRANCH: pc_nxt = out + in;
        OP_CALL: begin
          if (stack_full) begin
            fault_nxt = 1'b1;
          end else begin
            push      = 1'b1;
            depth_nxt = depth + ONE_D;
            pc_nxt    = in;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            fault_nxt = 1'b1;
          end else begin
            depth_nxt = depth - ONE_D;
            pc_nxt    = ret_top;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out   <= RESET_VEC;
      depth <= '0;
      fault <= 1'b0;
    end else begin
      out   <= pc_nxt;
      depth <= depth_nxt;
      fault <= fault_nxt;
    end
  end

  // Return-address storage needs no reset: entries above depth are never observed.
  always_ff @(posedge clk) begin
    if (push && reset) stk[wr_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios plus random ops against
// a queue-based reference model of the PC and return stack.
module tb_pc_stack;

  localparam int          WIDTH = 16;
  localparam int          DEPTH = 4;
  localparam int          INC   = 1;
  localparam logic [15:0] RV    = 16'h0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stahp = 1'b0;
  logic        of = 1'b0;
  logic        clear_fault = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] in = '0;
  logic [15:0] out;
  logic [15:0] ret_top;
  logic [2:0]  depth;
  logic        stack_full;
  logic        stack_empty;
  logic        fault;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mpc;
  bit          mfault;
  logic [15:0] mstk[$];

  pc_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .INC(INC),
    .RESET_VEC(RV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stahp(stahp),
    .of(of),
    .op(op),
    .in(in),
    .clear_fault(clear_fault),
    .out(out),
    .ret_top(ret_top),
    .depth(depth),
    .stack_full(stack_full),
    .stack_empty(stack_empty),
    .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    mpc    = RV;
    mfault = 1'b0;
    mstk.delete();
  endtask

  task automatic mstep(bit cf, bit st, bit ofv, logic [2:0] o, logic [15:0] i);
    if (cf) mfault = 1'b0;
    else if (mfault || st || ofv) ;
    else begin
      case (o)
        3'd1: mpc = mpc + 16'(INC);
        3'd2: mpc = i;
        3'd3: mpc = mpc + i;
        3'd4: if (mstk.size() == DEPTH) mfault = 1'b1;
              else begin mstk.push_back(mpc + 16'(INC)); mpc = i; end
        3'd5: if (mstk.size() == 0) mfault = 1'b1;
              else mpc = mstk.pop_back();
        default: ;
      endcase
    end
  endtask

  task automatic check_all(string tag);
    logic [15:0] etop;
    etop = (mstk.size() == 0) ? 16'h0000 : mstk[mstk.size()-1];
    chk({tag, ".out"},     out,         mpc);
    chk({tag, ".ret_top"}, ret_top,     etop);
    chk({tag, ".depth"},   depth,       mstk.size());
    chk({tag, ".full"},    stack_full,  mstk.size() == DEPTH);
    chk({tag, ".empty"},   stack_empty, mstk.size() == 0);
    chk({tag, ".fault"},   fault,       mfault);
  endtask

  task automatic step(string tag, logic [2:0] o, logic [15:0] i,
                      bit st = 1'b0, bit ofv = 1'b0, bit cf = 1'b0);
    op = o; in = i; stahp = st; of = ofv; clear_fault = cf;
    @(posedge clk);
    mstep(cf, st, ofv, o, i);
    #1;
    check_all(tag);
  endtask

  initial begin
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.out_const", out, 16'h0100);
    @(negedge clk) reset = 1'b1;

    for (int k = 0; k < 3; k++) step("inc", 3'd1, '0);
    chk("inc3.out_const", out, 16'h0103);

    step("jump", 3'd2, 16'hFFFE);
    step("wrap1", 3'd1, '0);
    step("wrap2", 3'd1, '0);
    chk("wrap.out_const", out, 16'h0000);

    step("jump200", 3'd2, 16'h0200);
    step("br_neg", 3'd3, 16'hFFFC);
    chk("br_neg.const", out, 16'h01FC);
    step("br_pos", 3'd3, 16'h0010);
    chk("br_pos.const", out, 16'h020C);

    step("jump10", 3'd2, 16'h0010);
    step("call1", 3'd4, 16'h0100);
    chk("call1.top_const", ret_top, 16'h0011);
    step("call2", 3'd4, 16'h0200);
    chk("call2.top_const", ret_top, 16'h0101);
    step("ret1", 3'd5, '0);
    chk("ret1.out_const", out, 16'h0101);
    step("ret2", 3'd5, '0);
    chk("ret2.out_const", out, 16'h0011);
    chk("ret2.top_const", ret_top, 16'h0000);

    for (int k = 1; k <= 4; k++) step("fill", 3'd4, 16'(k * 16'h1000));
    step("ovf", 3'd4, 16'h5000);
    chk("ovf.fault_const", fault, 1'b1);
    chk("ovf.out_const", out, 16'h4000);
    step("inc_faulted", 3'd1, '0);
    step("clr_call", 3'd4, 16'h6000, 1'b0, 1'b0, 1'b1);
    chk("clr.fault_const", fault, 1'b0);
    for (int k = 0; k < 4; k++) step("drain", 3'd5, '0);
    chk("drain.out_const", out, 16'h0012);
    step("unf", 3'd5, '0);
    chk("unf.fault_const", fault, 1'b1);
    step("clr2", 3'd0, '0, 1'b0, 1'b0, 1'b1);

    step("ret_stalled", 3'd5, '0, 1'b1, 1'b0);
    step("call_stahp", 3'd4, 16'h0700, 1'b1, 1'b0);
    step("call_of", 3'd4, 16'h0700, 1'b0, 1'b1);
    step("callA", 3'd4, 16'h0700);
    step("callB", 3'd4, 16'h0800);
    chk("pre_rst.depth_const", depth, 3'd2);
    #2 reset = 1'b0;
    mreset();
    #1;
    check_all("async_rst");
    chk("async_rst.out_const", out, 16'h0100);
    @(negedge clk) reset = 1'b1;

    for (int n = 0; n < 400; n++) begin
      logic [2:0]  o;
      logic [15:0] i;
      bit st, ofv, cf;
      o   = 3'($urandom_range(0, 7));
      i   = 16'($urandom);
      st  = ($urandom_range(0, 9) == 0);
      ofv = ($urandom_range(0, 9) == 0);
      cf  = mfault ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      step("rand", o, i, st, ofv, cf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
